// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: 1-cycle-latency read port into a 2-entry skid buffer, framed into bursts.
// Optional macro FIFO_RD_STREAM_PARITY_EN adds an even-parity bit on read data and an O_PAR_ERR output.
module fifo_rd_stream #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 4,
  localparam int BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_EN,
  input  logic          I_RD_EMPTY,
  output logic          O_RD_REQ,
`ifdef FIFO_RD_STREAM_PARITY_EN
  input  logic [DW:0]   I_RD_DATA,
`else
  input  logic [DW-1:0] I_RD_DATA,
`endif
  output logic          O_VALID,
  input  logic          I_READY,
  output logic [DW-1:0] O_DATA,
  output logic          O_LAST,
  output logic [BW-1:0] O_BEAT_CNT,
  output logic          O_IDLE
`ifdef FIFO_RD_STREAM_PARITY_EN
  ,
  output logic          O_PAR_ERR
`endif
);

`ifdef FIFO_RD_STREAM_PARITY_EN
  localparam int EW = DW + 1;

  function automatic logic par_err(input logic [DW:0] word);
    return ^word;
  endfunction
`else
  localparam int EW = DW;
`endif

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [EW-1:0]       buf_q [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          cnt;
  logic [BW-1:0]       beat_cnt;
  logic                pop;
  logic signed [2:0]   credit_p0;
  logic                rd_acc_p0;
  logic                rd_vld_p1;
  logic [EW-1:0]       wr_word_p1;
  logic [EW-1:0]       head;

  // ---- p0: request issue; credit counts free slots not yet promised to an in-flight read
  always_comb begin
    pop       = O_VALID && I_READY;
    credit_p0 = 3'sd2 - $signed({1'b0, cnt}) - $signed({2'b00, rd_vld_p1})
                + $signed({2'b00, pop});
    O_RD_REQ  = I_RST_N && I_EN && !I_RD_EMPTY && (credit_p0 > 3'sd0);
    rd_acc_p0 = O_RD_REQ && !I_RD_EMPTY;
  end

  // ---- p1: read data arrives and is appended to the skid buffer
  always_comb begin
`ifdef FIFO_RD_STREAM_PARITY_EN
    wr_word_p1 = {par_err(I_RD_DATA), I_RD_DATA[DW-1:0]};
`else
    wr_word_p1 = I_RD_DATA;
`endif
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      rd_vld_p1 <= 1'b0;
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      rd_vld_p1 <= rd_acc_p0;
      cnt       <= cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
      if (rd_vld_p1)
        wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // Storage is data only; slot contents are masked by O_VALID so they never need clearing
  always_ff @(posedge I_CLK) begin
    if (rd_vld_p1)
      buf_q[wr_ptr] <= wr_word_p1;
  end

  // ---- p2: buffer head presented on the output stream
  always_comb begin
    head       = buf_q[rd_ptr];
    O_VALID    = (cnt != 2'd0);
    O_DATA     = O_VALID ? head[DW-1:0] : '0;
    O_LAST     = O_VALID && (beat_cnt == LAST_BEAT);
    O_BEAT_CNT = beat_cnt;
    O_IDLE     = (cnt == 2'd0) && !rd_vld_p1 && I_RD_EMPTY;
  end

`ifdef FIFO_RD_STREAM_PARITY_EN
  assign O_PAR_ERR = O_VALID && head[DW];
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural 1-cycle-latency FIFO source, linear stimulus, immediate assertions.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          rd_empty;
  logic          rd_req;
  logic          rd_req1;
  logic [DW-1:0] rd_data;
  logic          valid, valid1;
  logic          ready;
  logic [DW-1:0] data, data1;
  logic          last, last1;
  logic [1:0]    beat;
  logic [0:0]    beat1;
  logic          idle, idle1;

`ifdef FIFO_RD_STREAM_PARITY_EN
  logic [DW:0]   rd_bus;
  logic          par_err, par_err1;
  assign rd_bus = {^rd_data, rd_data};
`else
  logic [DW-1:0] rd_bus;
  assign rd_bus = rd_data;
`endif

  logic [DW-1:0] fifo_q [$];
  int n_chk = 0;
  int n_err = 0;

  fifo_rd_stream #(.DW(DW), .BURST_LEN(BL)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_RD_EMPTY(rd_empty),
    .O_RD_REQ(rd_req), .I_RD_DATA(rd_bus), .O_VALID(valid), .I_READY(ready),
    .O_DATA(data), .O_LAST(last), .O_BEAT_CNT(beat), .O_IDLE(idle)
`ifdef FIFO_RD_STREAM_PARITY_EN
    , .O_PAR_ERR(par_err)
`endif
  );

  fifo_rd_stream #(.DW(DW), .BURST_LEN(1)) dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_RD_EMPTY(rd_empty),
    .O_RD_REQ(rd_req1), .I_RD_DATA(rd_bus), .O_VALID(valid1), .I_READY(ready),
    .O_DATA(data1), .O_LAST(last1), .O_BEAT_CNT(beat1), .O_IDLE(idle1)
`ifdef FIFO_RD_STREAM_PARITY_EN
    , .O_PAR_ERR(par_err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    rd_empty = 1'b0;
  endtask

  // Source FIFO: a read accepted at an edge presents its word just after that edge
  task automatic tick();
    logic acc;
    acc = (rd_req === 1'b1) && !rd_empty;
    @(posedge clk);
    #1;
    if (acc && fifo_q.size() > 0)
      rd_data = fifo_q.pop_front();
    rd_empty = (fifo_q.size() == 0);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int got;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic [1:0] prev_beat;
    logic rp [7];
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b1; ready = 1'b0; rd_data = '0; rd_empty = 1'b1;
    tick(); tick();

    // reset with an empty then a loaded FIFO
    #1; chk("rst_idle_empty", 64'(idle), 64'(1));
    push(32'hA0); push(32'hA1); push(32'hA2);
    #1;
    chk("rst_idle_full", 64'(idle), 64'(0));
    chk("rst_req", 64'(rd_req), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_beat", 64'(beat), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_last", 64'(last), 64'(0));
    tick();

    // first request after release; valid two cycles later
    rst_n = 1'b1;
    #1; chk("rel_req", 64'(rd_req), 64'(1)); chk("rel_valid_c0", 64'(valid), 64'(0));
    tick();
    #1; chk("rel_valid_c1", 64'(valid), 64'(0));
    tick();
    #1;
    chk("rel_valid_c2", 64'(valid), 64'(1));
    chk("rel_data_c2", 64'(data), 64'(32'hA0));
    chk("rel_beat_c2", 64'(beat), 64'(0));
    chk("rel_req_full", 64'(rd_req), 64'(0));
    tick();
    #1; chk("stall_data", 64'(data), 64'(32'hA0)); chk("stall_req", 64'(rd_req), 64'(0));
    tick();

    // reset mid-operation with two buffered words
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'(0));
    chk("mid_rst_data", 64'(data), 64'(0));
    chk("mid_rst_beat", 64'(beat), 64'(0));
    chk("mid_rst_req", 64'(rd_req), 64'(0));
    tick(); tick();
    rst_n = 1'b1; ready = 1'b1;
    #1; chk("resume_req", 64'(rd_req), 64'(1));
    tick();
    #1; chk("resume_valid_c1", 64'(valid), 64'(0));
    tick();
    #1;
    chk("resume_valid", 64'(valid), 64'(1));
    chk("resume_data", 64'(data), 64'(32'hA2));
    chk("resume_beat", 64'(beat), 64'(0));
    chk("resume_last", 64'(last), 64'(0));
    tick();
    #1; chk("resume_done_valid", 64'(valid), 64'(0)); chk("resume_idle", 64'(idle), 64'(1));
    tick();

    // streaming 8 words at full rate
    rst_pulse();
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("str_req_eq", 64'(rd_req1), 64'(rd_req));
      if (c >= 2 && c <= 9) begin
        chk("str_valid", 64'(valid), 64'(1));
        chk("str_data", 64'(data), 64'(32'h10 + 32'(c - 2)));
        chk("str_last", 64'(last), 64'((c - 2) % 4 == 3));
        chk("str_beat", 64'(beat), 64'((c - 2) % 4));
        chk("bl1_data", 64'(data1), 64'(32'h10 + 32'(c - 2)));
        chk("bl1_last", 64'(last1), 64'(1));
        chk("bl1_beat", 64'(beat1), 64'(0));
`ifdef FIFO_RD_STREAM_PARITY_EN
        chk("str_par", 64'(par_err), 64'(0));
`endif
      end else if (c >= 10) begin
        chk("str_end_valid", 64'(valid), 64'(0));
        chk("bl1_end_last", 64'(last1), 64'(0));
      end
      tick();
    end

    // backpressure on a 6-word stream
    for (int i = 0; i < 6; i++) push(32'h20 + 32'(i));
    got = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; prev_beat = '0;
    for (int c = 0; c < 30; c++) begin
      ready = (c >= 2 && c < 9) ? rp[c - 2] : 1'b1;
      #1;
      if (prev_stall) begin
        chk("bp_hold_data", 64'(data), 64'(prev_data));
        chk("bp_hold_last", 64'(last), 64'(prev_last));
        chk("bp_hold_beat", 64'(beat), 64'(prev_beat));
      end
      chk("bp_cnt_max", 64'(dut.cnt <= 2'd2), 64'(1));
      if (valid && ready) begin
        chk("bp_data", 64'(data), 64'(32'h20 + 32'(got)));
        chk("bp_last", 64'(last), 64'(got == 3));
        chk("bp_beat", 64'(beat), 64'(got % 4));
        got++;
      end
      prev_stall = valid && !ready;
      prev_data = data; prev_last = last; prev_beat = beat;
      tick();
    end
    chk("bp_count", 64'(got), 64'(6));

    // FIFO empties mid-burst, refills later
    rst_pulse();
    push(32'h30); push(32'h31);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 2) begin chk("gap_d0", 64'(data), 64'(32'h30)); chk("gap_b0", 64'(beat), 64'(0)); end
      if (c == 3) begin chk("gap_d1", 64'(data), 64'(32'h31)); chk("gap_l1", 64'(last), 64'(0)); end
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("gap_idle", 64'(idle), 64'(1));
      chk("gap_valid", 64'(valid), 64'(0));
      tick();
    end
    push(32'h32); push(32'h33);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 2) begin
        chk("gap_d2", 64'(data), 64'(32'h32)); chk("gap_b2", 64'(beat), 64'(2));
        chk("gap_l2", 64'(last), 64'(0));
      end
      if (c == 3) begin
        chk("gap_d3", 64'(data), 64'(32'h33)); chk("gap_b3", 64'(beat), 64'(3));
        chk("gap_l3", 64'(last), 64'(1));
      end
      if (c == 4) chk("gap_end_valid", 64'(valid), 64'(0));
      tick();
    end

    // enable dropped the cycle after a request
    push(32'h40); push(32'h41); push(32'h42);
    #1; chk("en_req0", 64'(rd_req), 64'(1));
    tick();
    en = 1'b0;
    #1; chk("en_off_req", 64'(rd_req), 64'(0));
    tick();
    #1;
    chk("en_inflight_valid", 64'(valid), 64'(1));
    chk("en_inflight_data", 64'(data), 64'(32'h40));
    chk("en_inflight_beat", 64'(beat), 64'(0));
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("en_off_req_hold", 64'(rd_req), 64'(0));
      chk("en_off_valid", 64'(valid), 64'(0));
      tick();
    end
    en = 1'b1;
    #1; chk("en_on_req", 64'(rd_req), 64'(1));
    tick();
    #1; tick();
    #1; chk("en_d1", 64'(data), 64'(32'h41)); chk("en_b1", 64'(beat), 64'(1));
    tick();
    #1; chk("en_d2", 64'(data), 64'(32'h42)); chk("en_b2", 64'(beat), 64'(2));
    chk("en_l2", 64'(last), 64'(0));
    tick();
    #1; chk("en_end_valid", 64'(valid), 64'(0)); chk("en_end_idle", 64'(idle), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
